fft_bitrev_loader: RTL and testbench

FFT_BITREV_LOADER -- requirements
Module: fft_bitrev_loader

---
 rtl/fft_bitrev_loader.sv | 126 ++++++++++++
 tb/tb_fft_bitrev_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_loader.sv
// Ping-pong input buffer for an FFT core: streams samples into one bank (natural or
// bit-reversed order) while the core reads the other bank through two registered ports.
`timescale 1ns/1ps
module fft_bitrev_loader #(
  parameter int N  = 16,
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DW-1:0]         s_re_i,
  input  logic [DW-1:0]         s_im_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic                  s_last_i,
  input  logic                  rev_en_i,
  output logic                  start_o,
  input  logic [$clog2(N)-1:0]  rd_addr0_i,
  input  logic [$clog2(N)-1:0]  rd_addr1_i,
  output logic [DW-1:0]         x0_re_o,
  output logic [DW-1:0]         x0_im_o,
  output logic [DW-1:0]         x1_re_o,
  output logic [DW-1:0]         x1_im_o,
  input  logic                  frame_done_i,
  output logic                  busy_o,
  output logic                  err_last_o,
  output logic [3:0]            bank_state
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    BUSY    = 2'd3
  } bank_t;

  // Handshake: a sample moves on every rising edge where s_valid_i and s_ready_o are
  // both high; s_ready_o depends only on registered bank state, never on s_valid_i.

  bank_t             bank_q [2];
  logic              wr_bank;
  logic              rd_bank;
  logic [AW-1:0]     cnt;
  logic              mode_q;
  logic [DW-1:0]     mem_re [2*N];
  logic [DW-1:0]     mem_im [2*N];

  logic              accept;
  logic              mode_eff;
  logic              any_busy;
  logic [AW-1:0]     wr_addr;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] k);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = k[AW-1-i];
    return r;
  endfunction

  assign s_ready_o  = (bank_q[wr_bank] == EMPTY) || (bank_q[wr_bank] == FILLING);
  assign accept     = s_valid_i && s_ready_o;
  // The first sample of a frame already uses the incoming mode, later ones the latched copy.
  assign mode_eff   = (cnt == '0) ? rev_en_i : mode_q;
  assign wr_addr    = mode_eff ? bitrev(cnt) : cnt;
  assign any_busy   = (bank_q[0] == BUSY) || (bank_q[1] == BUSY);
  assign busy_o     = any_busy;
  assign bank_state = {bank_q[1], bank_q[0]};

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_re[{wr_bank, wr_addr}] <= s_re_i;
      mem_im[{wr_bank, wr_addr}] <= s_im_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_q[0]  <= EMPTY;
      bank_q[1]  <= EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      cnt        <= '0;
      mode_q     <= 1'b0;
      err_last_o <= 1'b0;
      start_o    <= 1'b0;
    end else begin
      start_o <= 1'b0;
      if (accept) begin
        if (cnt == '0) mode_q <= rev_en_i;
        if (s_last_i != (cnt == LAST)) err_last_o <= 1'b1;
        if (cnt == LAST) begin
          bank_q[wr_bank] <= FULL;
          cnt             <= '0;
          wr_bank         <= ~wr_bank;
        end else begin
          cnt <= cnt + 1'b1;
          if (bank_q[wr_bank] == EMPTY) bank_q[wr_bank] <= FILLING;
        end
      end
      // The write side only touches EMPTY/FILLING banks, so these never collide with it.
      if (frame_done_i && (bank_q[rd_bank] == BUSY)) begin
        bank_q[rd_bank] <= EMPTY;
        rd_bank         <= ~rd_bank;
      end else if ((bank_q[rd_bank] == FULL) && !any_busy) begin
        bank_q[rd_bank] <= BUSY;
        start_o         <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x0_re_o <= '0;
      x0_im_o <= '0;
      x1_re_o <= '0;
      x1_im_o <= '0;
    end else begin
      x0_re_o <= mem_re[{rd_bank, rd_addr0_i}];
      x0_im_o <= mem_im[{rd_bank, rd_addr0_i}];
      x1_re_o <= mem_re[{rd_bank, rd_addr1_i}];
      x1_im_o <= mem_im[{rd_bank, rd_addr1_i}];
    end
  end

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Directed bench for fft_bitrev_loader (N=16, DW=32): ordering, ping-pong flow control,
// framing errors, reset mid-frame and release/fill collisions.
`timescale 1ns/1ps
module tb_fft_bitrev_loader;
  localparam int N  = 16;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] s_re_i = '0;
  logic [DW-1:0] s_im_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic          s_last_i = 1'b0;
  logic          rev_en_i = 1'b0;
  logic          start_o;
  logic [AW-1:0] rd_addr0_i = '0;
  logic [AW-1:0] rd_addr1_i = '0;
  logic [DW-1:0] x0_re_o, x0_im_o, x1_re_o, x1_im_o;
  logic          frame_done_i = 1'b0;
  logic          busy_o;
  logic          err_last_o;
  logic [3:0]    bank_state;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;

  fft_bitrev_loader #(.N(N), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .s_re_i(s_re_i), .s_im_i(s_im_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_last_i(s_last_i),
    .rev_en_i(rev_en_i), .start_o(start_o),
    .rd_addr0_i(rd_addr0_i), .rd_addr1_i(rd_addr1_i),
    .x0_re_o(x0_re_o), .x0_im_o(x0_im_o), .x1_re_o(x1_re_o), .x1_im_o(x1_im_o),
    .frame_done_i(frame_done_i), .busy_o(busy_o), .err_last_o(err_last_o),
    .bank_state(bank_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start_o === 1'b1) start_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] re, input logic [DW-1:0] im,
                       input logic last, input logic rev, output logic acc);
    s_valid_i = 1'b1;
    s_re_i    = re;
    s_im_i    = im;
    s_last_i  = last;
    rev_en_i  = rev;
    acc       = s_ready_o;
    step();
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  // Sends samples k0..k1 of a frame: re = base+k, im = base+k+0x1000, s_last on k=15.
  task automatic send_frame(input logic [DW-1:0] base, input logic rev_first,
                            input logic rev_rest, input int k0, input int k1);
    logic acc;
    for (int k = k0; k <= k1; k++) begin
      drive(base + DW'(k), base + DW'(k) + 32'h1000, (k == N-1), (k == 0) ? rev_first : rev_rest, acc);
      checks++;
      if (acc !== 1'b1) begin
        errors++;
        $display("FAIL accept base=%0d k=%0d: ready=%b expected 1", base, k, acc);
      end
    end
  endtask

  task automatic release_bank();
    frame_done_i = 1'b1;
    step();
    frame_done_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    step();
    checks++; if (start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", start_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (err_last_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_last_o); end
    checks++; if (x0_re_o !== 32'd0 || x1_im_o !== 32'd0) begin errors++; $display("FAIL reset_data: got %0d/%0d expected 0/0", x0_re_o, x1_im_o); end
    rstn = 1'b1;
    step();
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", s_ready_o); end
  endtask

  task automatic test_bitrev();
    send_frame(32'd0, 1'b1, 1'b1, 0, N-1);
    checks++; if (start_o !== 1'b0) begin errors++; $display("FAIL rev_start_early: got %b expected 0", start_o); end
    step();
    checks++; if (start_o !== 1'b1) begin errors++; $display("FAIL rev_start_latency: got %b expected 1", start_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rev_busy: got %b expected 1", busy_o); end
    rd_addr0_i = 4'd8; rd_addr1_i = 4'd12;
    step();
    checks++; if (start_o !== 1'b0) begin errors++; $display("FAIL rev_start_pulse: got %b expected 0", start_o); end
    checks++; if (x0_re_o !== 32'd1) begin errors++; $display("FAIL rev_addr8: got %0d expected 1", x0_re_o); end
    checks++; if (x1_re_o !== 32'd3) begin errors++; $display("FAIL rev_addr12: got %0d expected 3", x1_re_o); end
    checks++; if (x0_im_o !== 32'h1001) begin errors++; $display("FAIL rev_addr8_im: got %0h expected 1001", x0_im_o); end
    rd_addr0_i = 4'd0; rd_addr1_i = 4'd6;
    step();
    checks++; if (x0_re_o !== 32'd0) begin errors++; $display("FAIL rev_addr0: got %0d expected 0", x0_re_o); end
    checks++; if (x1_re_o !== 32'd6) begin errors++; $display("FAIL rev_addr6: got %0d expected 6", x1_re_o); end
    checks++; if (err_last_o !== 1'b0) begin errors++; $display("FAIL rev_err: got %b expected 0", err_last_o); end
    release_bank();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rev_release: got %b expected 0", busy_o); end
  endtask

  // rev_en rises after the first sample: the frame must stay in natural order.
  task automatic test_natural();
    send_frame(32'd0, 1'b0, 1'b1, 0, N-1);
    rev_en_i = 1'b0;
    step();
    checks++; if (start_o !== 1'b1) begin errors++; $display("FAIL nat_start: got %b expected 1", start_o); end
    for (int k = 0; k < N; k++) begin
      rd_addr0_i = AW'(k);
      rd_addr1_i = AW'(N - 1 - k);
      step();
      checks++; if (x0_re_o !== DW'(k)) begin errors++; $display("FAIL nat_x0 k=%0d: got %0d expected %0d", k, x0_re_o, k); end
      checks++; if (x1_re_o !== DW'(N-1-k)) begin errors++; $display("FAIL nat_x1 k=%0d: got %0d expected %0d", k, x1_re_o, N-1-k); end
    end
    rd_addr0_i = 4'd5; rd_addr1_i = 4'd5;
    step();
    checks++; if (x0_re_o !== 32'd5 || x1_re_o !== 32'd5) begin errors++; $display("FAIL nat_same_addr: got %0d/%0d expected 5/5", x0_re_o, x1_re_o); end
    release_bank();
  endtask

  task automatic test_back_to_back();
    int  s0;
    bit  held_low;
    logic acc;
    s0 = start_cnt;
    send_frame(32'd1000, 1'b0, 1'b0, 0, N-1);
    send_frame(32'd2000, 1'b0, 1'b0, 0, N-1);
    s_valid_i = 1'b1; s_re_i = 32'd3000; s_im_i = 32'd3000 + 32'h1000; s_last_i = 1'b0;
    rd_addr0_i = 4'd0;
    held_low = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (s_ready_o !== 1'b0) held_low = 1'b0;
      step();
    end
    checks++; if (held_low !== 1'b1) begin errors++; $display("FAIL b2b_ready_full: ready rose while both banks occupied"); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL b2b_one_start: got %0d expected 1", start_cnt - s0); end
    checks++; if (x0_re_o !== 32'd1000) begin errors++; $display("FAIL b2b_busy_read: got %0d expected 1000", x0_re_o); end
    frame_done_i = 1'b1;
    step();
    frame_done_i = 1'b0;
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done: got %b expected 1", s_ready_o); end
    checks++; if (start_o !== 1'b0) begin errors++; $display("FAIL b2b_start_same: got %b expected 0", start_o); end
    drive(32'd3000, 32'd3000 + 32'h1000, 1'b0, 1'b0, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL b2b_accept33: got %b expected 1", acc); end
    checks++; if (start_o !== 1'b1) begin errors++; $display("FAIL b2b_second_start: got %b expected 1", start_o); end
    send_frame(32'd3000, 1'b0, 1'b0, 1, N-1);
    checks++; if (start_cnt - s0 !== 2) begin errors++; $display("FAIL b2b_start_count: got %0d expected 2", start_cnt - s0); end
    rd_addr0_i = 4'd15;
    step();
    checks++; if (x0_re_o !== 32'd2015) begin errors++; $display("FAIL b2b_frame2: got %0d expected 2015", x0_re_o); end
    release_bank();
    step();
    checks++; if (start_o !== 1'b1) begin errors++; $display("FAIL b2b_third_start: got %b expected 1", start_o); end
    rd_addr0_i = 4'd7;
    step();
    checks++; if (x0_re_o !== 32'd3007) begin errors++; $display("FAIL b2b_frame3: got %0d expected 3007", x0_re_o); end
    release_bank();
  endtask

  task automatic test_last_err();
    logic acc;
    for (int k = 0; k < N; k++) begin
      drive(32'd4000 + DW'(k), 32'd0, (k == 9) || (k == N-1), 1'b0, acc);
      if (k == 8) begin
        checks++; if (err_last_o !== 1'b0) begin errors++; $display("FAIL err_before: got %b expected 0", err_last_o); end
      end
      if (k == 9) begin
        checks++; if (err_last_o !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", err_last_o); end
      end
    end
    checks++; if (start_o !== 1'b0) begin errors++; $display("FAIL err_start_early: got %b expected 0", start_o); end
    step();
    checks++; if (start_o !== 1'b1) begin errors++; $display("FAIL err_frame_complete: got %b expected 1", start_o); end
    release_bank();
    checks++; if (err_last_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err_last_o); end
  endtask

  task automatic test_reset_mid();
    logic acc;
    for (int k = 0; k < 7; k++) drive(32'd9000 + DW'(k), 32'd0, 1'b0, 1'b0, acc);
    rstn = 1'b0;
    #1;
    checks++; if (start_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got start=%b busy=%b expected 0/0", start_o, busy_o); end
    checks++; if (err_last_o !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b expected 0", err_last_o); end
    checks++; if (x0_re_o !== 32'd0 || x1_re_o !== 32'd0) begin errors++; $display("FAIL rst_mid_data: got %0d/%0d expected 0/0", x0_re_o, x1_re_o); end
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", s_ready_o); end
    step();
    rstn = 1'b1;
    step();
    send_frame(32'd5000, 1'b1, 1'b1, 0, N-1);
    checks++; if (start_o !== 1'b0) begin errors++; $display("FAIL rst_mid_start_early: got %b expected 0", start_o); end
    step();
    checks++; if (start_o !== 1'b1) begin errors++; $display("FAIL rst_mid_start: got %b expected 1", start_o); end
    rd_addr0_i = 4'd8; rd_addr1_i = 4'd0;
    step();
    checks++; if (x0_re_o !== 32'd5001 || x1_re_o !== 32'd5000) begin errors++; $display("FAIL rst_mid_data2: got %0d/%0d expected 5001/5000", x0_re_o, x1_re_o); end
    checks++; if (x0_im_o !== 32'd5001 + 32'h1000) begin errors++; $display("FAIL rst_mid_im: got %0d expected %0d", x0_im_o, 32'd5001 + 32'h1000); end
    release_bank();
  endtask

  task automatic test_done_same_cycle();
    logic acc;
    send_frame(32'd6000, 1'b0, 1'b0, 0, N-1);
    step();
    checks++; if (start_o !== 1'b1) begin errors++; $display("FAIL dsc_start_a: got %b expected 1", start_o); end
    send_frame(32'd7000, 1'b0, 1'b0, 0, N-2);
    frame_done_i = 1'b1;
    drive(32'd7015, 32'd7015 + 32'h1000, 1'b1, 1'b0, acc);
    frame_done_i = 1'b0;
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL dsc_accept16: got %b expected 1", acc); end
    checks++; if (busy_o !== 1'b0 || start_o !== 1'b0) begin errors++; $display("FAIL dsc_release: got busy=%b start=%b expected 0/0", busy_o, start_o); end
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL dsc_ready: got %b expected 1", s_ready_o); end
    step();
    checks++; if (start_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL dsc_start_b: got start=%b busy=%b expected 1/1", start_o, busy_o); end
    rd_addr0_i = 4'd3;
    step();
    checks++; if (x0_re_o !== 32'd7003) begin errors++; $display("FAIL dsc_rd_bank: got %0d expected 7003", x0_re_o); end
    release_bank();
  endtask

  initial begin
    test_reset();
    test_bitrev();
    test_natural();
    test_back_to_back();
    test_last_err();
    test_reset_mid();
    test_done_same_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
